// File: rtl/bitop_pipe.sv
// Two-stage bitwise logic unit (AND/OR/XOR/NAND/NOR/XNOR plus AND/OR accumulate); BITOP_STATS_EN enables the op_count statistic.
// Latency: the input-transfer edge loads S1, the next edge loads S2 (q/flags); one beat per cycle when out_ready stays high.
// Backpressure: holds up to two beats; in_ready = !s1_valid || s2_load, so releasing out_ready reopens input in the same cycle.
module bitop_pipe #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [31:0]      op_count
);

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_XOR     = 3'd2;
    localparam logic [2:0] OP_NAND    = 3'd3;
    localparam logic [2:0] OP_NOR     = 3'd4;
    localparam logic [2:0] OP_XNOR    = 3'd5;
    localparam logic [2:0] OP_ACC_AND = 3'd6;
    localparam logic [2:0] OP_ACC_OR  = 3'd7;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_result;
    logic             s2_valid;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result;
    logic             is_acc_op;
    logic             s2_load;
    logic             in_fire;

    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    // Reset gating keeps the upstream from seeing ready while both stages are being flushed.
    assign in_ready  = !rst && (!s1_valid || s2_load);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign is_acc_op = (op == OP_ACC_AND) || (op == OP_ACC_OR);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:     result = a & b;
            OP_OR:      result = a | b;
            OP_XOR:     result = a ^ b;
            OP_NAND:    result = ~(a & b);
            OP_NOR:     result = ~(a | b);
            OP_XNOR:    result = ~(a ^ b);
            OP_ACC_AND: result = acc & a;
            OP_ACC_OR:  result = acc | a;
            default:    result = '0;
        endcase
    end

    // Clear has priority: a coinciding ACC beat still computes against the old acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= ACC_INIT;
        end else if (acc_clr) begin
            acc <= ACC_INIT;
        end else if (in_fire && is_acc_op) begin
            acc <= result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_result <= '0;
        end else if (in_fire) begin
            s1_valid  <= 1'b1;
            s1_result <= result;
        end else if (s2_load) begin
            s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            q        <= '0;
            zero     <= 1'b1;
            ones     <= 1'b0;
            parity   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            q        <= s1_result;
            zero     <= (s1_result == '0);
            ones     <= &s1_result;
            parity   <= ^s1_result;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

`ifdef BITOP_STATS_EN
    logic        out_fire;
    logic [31:0] op_count_q;

    assign out_fire = s2_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (out_fire && (op_count_q != 32'hFFFF_FFFF)) begin
            op_count_q <= op_count_q + 32'd1;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_bitop_pipe.sv
// Directed bench for bitop_pipe (WIDTH=8): handshake, opcodes, stall/drain, accumulator, reset flush, op_count.
module tb_bitop_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    logic        zero;
    logic        ones;
    logic        parity;
    logic [31:0] op_count;

    int vectors = 0;
    int errors  = 0;
    int exp_xfers = 0;

    bitop_pipe #(.WIDTH(8), .ACC_INIT(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .zero      (zero),
        .ones      (ones),
        .parity    (parity),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_count(input int n);
`ifdef BITOP_STATS_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    // One isolated beat: present, let it reach S2, check q and flags, then let it transfer.
    task automatic beat(input string tag, input logic [2:0] o, input logic [7:0] va,
                        input logic [7:0] vb, input logic clr, input logic [7:0] exp_q);
        in_valid = 1'b1;
        op       = o;
        a        = va;
        b        = vb;
        acc_clr  = clr;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        chk({tag, "_s1_only"}, out_valid, 1'b0);
        tick();
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_q"}, q, exp_q);
        chk({tag, "_zero"}, zero, exp_q == 8'h00);
        chk({tag, "_ones"}, ones, exp_q == 8'hFF);
        chk({tag, "_parity"}, parity, ^exp_q);
        tick();
        exp_xfers++;
    endtask

    logic [7:0] exp_ops [6] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55};
    logic [7:0] vals [4]    = '{8'h01, 8'h80, 8'h7E, 8'hFF};

    initial begin
        int nxt;
        logic acc_ok;
        logic [7:0] got [$];

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; acc_clr = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_q", q, 8'h00);
        chk("rst_zero", zero, 1'b1);
        chk("rst_ones", ones, 1'b0);
        chk("rst_parity", parity, 1'b0);
        chk("rst_op_count", op_count, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Single XOR beat.
        out_ready = 1'b1;
        beat("xor", 3'd2, 8'hF0, 8'h3C, 1'b0, 8'hCC);
        chk("xor_one_cycle", out_valid, 1'b0);

        // Back-to-back opcodes 0..5: output trails input by two loop iterations.
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                in_valid = 1'b1; op = 3'(i); a = 8'hA5; b = 8'h0F;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 6) chk($sformatf("b2b_in_ready%0d", i), in_ready, 1'b1);
            if (i >= 2) begin
                chk($sformatf("b2b_valid%0d", i - 2), out_valid, 1'b1);
                chk($sformatf("b2b_q%0d", i - 2), q, exp_ops[i - 2]);
            end
            tick();
        end
        exp_xfers += 6;
        chk("b2b_drained", out_valid, 1'b0);

        // Stall: four beats offered with out_ready low, only two fit.
        out_ready = 1'b0;
        nxt = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; op = 3'd1; a = vals[nxt]; b = 8'h00;
            #1;
            acc_ok = in_ready;
            tick();
            if (acc_ok) nxt++;
        end
        chk("stall_accepted", nxt, 2);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_out_valid", out_valid, 1'b1);
        chk("stall_q", q, 8'h01);
        tick();
        chk("stall_q_hold", q, 8'h01);
        chk("stall_zero_hold", zero, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("restart_in_ready", in_ready, 1'b1);
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            in_valid = (nxt < 4);
            if (nxt < 4) a = vals[nxt];
            #1;
            if (out_valid) got.push_back(q);
            acc_ok = in_valid && in_ready;
            tick();
            if (acc_ok) nxt++;
        end
        in_valid = 1'b0;
        chk("drain_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk($sformatf("drain_q%0d", i), got[i], vals[i]);
        end
        exp_xfers += 4;
        tick();
        chk("drain_empty", out_valid, 1'b0);

        // Accumulator, including clear colliding with an ACC beat.
        beat("acc_and1", 3'd6, 8'hF3, 8'h00, 1'b0, 8'hF3);
        beat("acc_and2", 3'd6, 8'h3F, 8'hFF, 1'b0, 8'h33);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        beat("acc_or_clr", 3'd7, 8'h01, 8'h00, 1'b0, 8'hFF);
        beat("acc_and3", 3'd6, 8'h3C, 8'h00, 1'b0, 8'h3C);
        beat("acc_or_coll", 3'd7, 8'h41, 8'h00, 1'b1, 8'h7D);
        beat("acc_after_coll", 3'd6, 8'h0F, 8'h00, 1'b0, 8'h0F);

        chk("op_count_pre_rst", op_count, exp_count(exp_xfers));

        // Fill both stages, then reset mid-stream.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd0; a = 8'hFF; b = 8'hFF;
        tick();
        tick();
        in_valid = 1'b0;
        chk("full_out_valid", out_valid, 1'b1);
        chk("full_in_ready", in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_q", q, 8'h00);
        chk("midrst_zero", zero, 1'b1);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_op_count", op_count, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("midrst_hold_valid", out_valid, 1'b0);
        rst = 1'b0;
        tick();
        chk("after_rst_valid", out_valid, 1'b0);
        chk("after_rst_in_ready", in_ready, 1'b1);

        // Five transfers after reset.
        exp_xfers = 0;
        for (int i = 0; i < 5; i++) begin
            beat($sformatf("cnt%0d", i), 3'd5, 8'(i), 8'h00, 1'b0, ~8'(i));
        end
        chk("op_count_five", op_count, exp_count(5));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
